// File: rtl/fetch_queue_stage.sv
// Fetch stage with an in-order instruction queue.
// Owns the fetch PC and issues requests to a variable-latency instruction
// memory. Returned instructions are buffered with their PCs and handed to
// decode over a valid/ready stream. A taken-branch redirect flushes the queue;
// responses still in flight for flushed entries are counted and then discarded.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            PCSrc,
  input  logic            PCWrite,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] pc
);

  localparam int              PTR_W  = $clog2(DEPTH);
  localparam int              CNT_W  = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(ILEN / 8);

  // Architectural state
  logic [XLEN-1:0]  pc_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] alloc_reg;
  logic [PTR_W-1:0] fill_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] drop_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] drop_next;

  // Queue storage (small, so kept in registers for a combinational head read)
  logic [XLEN-1:0]  q_pc     [DEPTH];
  logic [ILEN-1:0]  q_instr  [DEPTH];
  logic             filled_reg [DEPTH];

  // Derived control
  logic [CNT_W-1:0] filled_cnt;
  logic [CNT_W-1:0] unfilled;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W:0]   drop_sum;
  logic             req_valid;
  logic             issue;
  logic             head_valid;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;

  // Number of allocated entries that already hold their instruction
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CNT_W'(filled_reg[i]);
    end
  end

  assign unfilled  = count_reg - filled_cnt;
  // Stale responses still occupy memory-side slots, so they count against issue
  assign occupancy = {1'b0, count_reg} + {1'b0, drop_reg};

  // Issue depends only on registered state and strobes, never on ready
  assign req_valid  = PCWrite & ~PCSrc & ~rst & (occupancy < (CNT_W+1)'(DEPTH));
  assign issue      = req_valid & imem_req_ready;
  assign head_valid = ~rst & ~PCSrc & (count_reg != '0) & filled_reg[head_reg];
  assign pop        = head_valid & if_ready;
  assign rsp_drop   = imem_rsp_valid & (drop_reg != '0);
  assign rsp_fill   = imem_rsp_valid & (drop_reg == '0) & (unfilled != '0) & ~PCSrc & ~rst;

  // Next occupancy: redirect flushes, otherwise issue and pop cancel out
  always_comb begin
    count_next = count_reg;
    if (PCSrc) begin
      count_next = '0;
    end else if (issue && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!issue && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Next stale-response count: a redirect turns every pending fill into a drop,
  // and a response arriving in the redirect cycle is itself one of them
  always_comb begin
    drop_sum  = {1'b0, drop_reg} + {1'b0, unfilled};
    drop_next = drop_reg;
    if (PCSrc) begin
      if (imem_rsp_valid && (drop_sum != '0)) begin
        drop_sum = drop_sum - (CNT_W+1)'(1);
      end
      drop_next = drop_sum[CNT_W-1:0];
    end else if (rsp_drop) begin
      drop_next = drop_reg - CNT_W'(1);
    end
  end

  // PC, pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      alloc_reg <= '0;
      fill_reg  <= '0;
      count_reg <= '0;
      drop_reg  <= '0;
    end else begin
      count_reg <= count_next;
      drop_reg  <= drop_next;
      if (PCSrc) begin
        pc_reg    <= pc_branch;
        head_reg  <= '0;
        alloc_reg <= '0;
        fill_reg  <= '0;
      end else begin
        if (issue) begin
          pc_reg    <= pc_reg + PC_INC;
          alloc_reg <= alloc_reg + PTR_W'(1);
        end
        if (rsp_fill) begin
          fill_reg <= fill_reg + PTR_W'(1);
        end
        if (pop) begin
          head_reg <= head_reg + PTR_W'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Entry payload: PC captured at allocation, instruction captured at fill
    always_ff @(posedge clk) begin
      if (issue && (alloc_reg == PTR_W'(gi))) begin
        q_pc[gi] <= pc_reg;
      end
      if (rsp_fill && (fill_reg == PTR_W'(gi))) begin
        q_instr[gi] <= imem_rsp_data;
      end
    end

    // Entry filled flag: set on fill, cleared on pop, flush or reset
    always_ff @(posedge clk) begin
      if (rst || PCSrc) begin
        filled_reg[gi] <= 1'b0;
      end else if (rsp_fill && (fill_reg == PTR_W'(gi))) begin
        filled_reg[gi] <= 1'b1;
      end else if (pop && (head_reg == PTR_W'(gi))) begin
        filled_reg[gi] <= 1'b0;
      end
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc_reg;
  assign if_valid       = head_valid;
  assign if_pc          = q_pc[head_reg];
  assign if_instr       = q_instr[head_reg];
  assign pc             = pc_reg;

  // A response must land on either a stale slot or an allocated, unfilled entry
  a_rsp_has_slot: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((drop_reg != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage against a queue-based reference model
// and an in-order variable-latency instruction memory model.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_branch;
  logic            PCSrc;
  logic            PCWrite;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] pc;

  fetch_queue_stage #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .pc_branch(pc_branch), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ent_t        mq_ent[$];   // model: allocated entries, oldest first
  mreq_t       mem_q[$];    // memory: accepted requests awaiting response
  int          m_drop;
  logic [31:0] m_pc;
  int          cyc;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq_ent.delete();
    mem_q.delete();
    m_drop = 0;
    m_pc   = RESET_PC;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model
  task automatic step(input int pb, input int pw, input int pr, input int pir,
                      input int prst, input int maxlat);
    bit    e_rv, e_iv, do_pop;
    int    unf, k, lat;
    mreq_t mr;
    ent_t  ne;
    @(negedge clk);
    cyc++;
    rst            = ($urandom_range(0, 999) < prst);
    PCSrc          = !rst && ($urandom_range(0, 99) < pb);
    case ($urandom_range(0, 3))
      0:       pc_branch = 32'h0000_0100;
      1:       pc_branch = 32'hFFFF_FFF8;
      default: pc_branch = $urandom & 32'hFFFF_FFFC;
    endcase
    PCWrite        = ($urandom_range(0, 99) < pw);
    imem_req_ready = ($urandom_range(0, 99) < pr);
    if_ready       = ($urandom_range(0, 99) < pir);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(0, 99) < pr) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_fn(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    #1;
    e_rv = !rst && PCWrite && !PCSrc && (mq_ent.size() + m_drop < DEPTH);
    e_iv = !rst && !PCSrc && mq_ent.size() > 0 && mq_ent[0].filled;
    check_val("imem_req_valid", 64'(imem_req_valid), 64'(e_rv));
    if (e_rv) check_val("imem_addr", 64'(imem_addr), 64'(m_pc));
    check_val("if_valid", 64'(if_valid), 64'(e_iv));
    if (e_iv) begin
      check_val("if_pc", 64'(if_pc), 64'(mq_ent[0].pc));
      check_val("if_instr", 64'(if_instr), 64'(mem_fn(mq_ent[0].pc)));
    end
    check_val("pc", 64'(pc), 64'(m_pc));

    if (rst) begin
      model_reset();
    end else if (PCSrc) begin
      unf = 0;
      foreach (mq_ent[i]) if (!mq_ent[i].filled) unf++;
      m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
      mq_ent.delete();
      m_pc = pc_branch;
    end else begin
      do_pop = e_iv && if_ready;
      if (imem_rsp_valid) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          k = -1;
          foreach (mq_ent[i]) if (k < 0 && !mq_ent[i].filled) k = i;
          if (k >= 0) begin
            mq_ent[k].filled = 1'b1;
            mq_ent[k].instr  = imem_rsp_data;
          end
        end
      end
      if (do_pop) void'(mq_ent.pop_front());
      if (e_rv && imem_req_ready) begin
        lat       = $urandom_range(1, maxlat);
        ne.pc     = m_pc;
        ne.instr  = '0;
        ne.filled = 1'b0;
        mq_ent.push_back(ne);
        mr.addr = m_pc;
        mr.due  = cyc + lat;
        mem_q.push_back(mr);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Phase table: length, branch %, PCWrite %, mem ready %, decode ready %,
  // reset per-mille, max memory latency
  int ph_len [8] = '{40, 20, 20, 300, 300, 500, 500, 300};
  int ph_pb  [8] = '{0,  0,  0,  15,  5,   10,  20,  3};
  int ph_pw  [8] = '{100,100,100, 90, 30,  80,  70,  100};
  int ph_pr  [8] = '{100,100,100, 70, 80,  60,  50,  90};
  int ph_pir [8] = '{100, 0, 100, 70, 80,  50,  50,  10};
  int ph_rst [8] = '{0,  0,  0,   0,  0,   10,  5,   20};
  int ph_lat [8] = '{1,  1,  1,   3,  4,   4,   5,   2};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst = 1'b1; PCSrc = 1'b0; PCWrite = 1'b0; pc_branch = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_pc", 64'(pc), 64'(RESET_PC));
    check_val("reset_req_valid", 64'(imem_req_valid), 64'd0);
    check_val("reset_if_valid", 64'(if_valid), 64'd0);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        step(ph_pb[p], ph_pw[p], ph_pr[p], ph_pir[p], ph_rst[p], ph_lat[p]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
